// File: rtl/dcache_axi_bridge.sv
// dcache_axi_bridge: memory-side stage below the data-cache controller.
// It turns a held load-miss request into one INCR line-fill burst and a held store into
// one single-beat write-through. mem_ready pulses for one cycle when the transaction ends.
// Only one transaction is in flight at a time.
// Optional build macro DCACHE_BRIDGE_ERR_EN adds a sticky bus_err output. It is set on
// any nonzero rresp or bresp.
module dcache_axi_bridge #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LINE_WORDS = 4,
    parameter logic [3:0]  AXI_ID     = 4'd0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_valid,
    input  logic                    mem_for_store,
    input  logic [ADDR_W-1:0]       mem_addr,
    input  logic [31:0]             mem_wdata,
    input  logic [3:0]              mem_wstrb,
    output logic                    mem_ready,
    output logic [32*LINE_WORDS-1:0] mem_rdata_line,
    output logic [3:0]              arid,
    output logic [ADDR_W-1:0]       araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [31:0]             rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready,
    output logic [3:0]              awid,
    output logic [ADDR_W-1:0]       awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [31:0]             wdata,
    output logic [3:0]              wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
`ifdef DCACHE_BRIDGE_ERR_EN
    ,
    output logic                    bus_err
`endif
);

    localparam int unsigned CNT_W = $clog2(LINE_WORDS);
    localparam int unsigned OFF_W = CNT_W + 2;
    localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFF_W;
    localparam logic [ADDR_W-1:0] WORD_MASK = {ADDR_W{1'b1}} << 2;

    typedef enum logic [2:0] {StIdle, StAr, StR, StWr, StB, StDone} state_e;

    state_e                  state_q, state_d;
    logic                    aw_pend_q, aw_pend_d;
    logic                    w_pend_q, w_pend_d;
    logic [ADDR_W-1:0]       addr_q;
    logic [31:0]             wdata_q;
    logic [3:0]              wstrb_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [32*LINE_WORDS-1:0] line_q;

    // State register plus the independent AW/W outstanding flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
        end
    end

    // Next-state logic; AW and W retire independently, B waits for both.
    always_comb begin
        state_d   = state_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        case (state_q)
            StIdle: begin
                if (mem_valid) begin
                    if (mem_for_store) begin
                        state_d   = StWr;
                        aw_pend_d = 1'b1;
                        w_pend_d  = 1'b1;
                    end else begin
                        state_d = StAr;
                    end
                end
            end
            StAr:   if (arready) state_d = StR;
            StR:    if (rvalid && rlast) state_d = StDone;
            StWr: begin
                aw_pend_d = aw_pend_q & ~awready;
                w_pend_d  = w_pend_q & ~wready;
                if (!aw_pend_d && !w_pend_d) state_d = StB;
            end
            StB:    if (bvalid) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Request capture and refill-line assembly; the line holds until the next refill beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            cnt_q   <= '0;
            line_q  <= '0;
        end else begin
            if (state_q == StIdle && mem_valid) begin
                if (mem_for_store) begin
                    addr_q  <= mem_addr & WORD_MASK;
                    wdata_q <= mem_wdata;
                    wstrb_q <= mem_wstrb;
                end else begin
                    addr_q <= mem_addr & LINE_MASK;
                    cnt_q  <= '0;
                end
            end
            // Surplus beats wrap the counter and overwrite earlier words; rlast alone ends it.
            if (state_q == StR && rvalid) begin
                line_q[{cnt_q, 5'b0} +: 32] <= rdata;
                cnt_q                       <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign mem_ready      = (state_q == StDone);
    assign mem_rdata_line = line_q;

    assign arid    = AXI_ID;
    assign araddr  = addr_q;
    assign arlen   = 8'(LINE_WORDS - 1);
    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign arvalid = (state_q == StAr);
    assign rready  = (state_q == StR);

    assign awid    = AXI_ID;
    assign awaddr  = addr_q;
    assign awlen   = 8'd0;
    assign awsize  = 3'b010;
    assign awburst = 2'b01;
    assign awvalid = (state_q == StWr) && aw_pend_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wlast   = 1'b1;
    assign wvalid  = (state_q == StWr) && w_pend_q;
    assign bready  = (state_q == StB);

`ifdef DCACHE_BRIDGE_ERR_EN
    logic bus_err_q;

    // Sticky error flag over every accepted read beat and write response.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_err_q <= 1'b0;
        end else if ((rvalid && rready && rresp != 2'b00) ||
                     (bvalid && bready && bresp != 2'b00)) begin
            bus_err_q <= 1'b1;
        end
    end

    assign bus_err = bus_err_q;
`else
    logic unused_resp;
    assign unused_resp = ^{rresp, bresp};
`endif

endmodule
